// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO slice.
// Optional first-word-fall-through read mode: SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int AF_LEVEL_DEF   = 6;
    localparam int AE_LEVEL_DEF   = 2;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo: requests, data, status, errors.
// master drives requests, slave (the FIFO) drives data and status.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic                  w_inc;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  r_inc;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  rd_valid;
    logic                  w_full;
    logic                  r_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_inc, WR_DATA, r_inc, clr_err,
        input  RD_DATA, rd_valid, w_full, r_empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  w_inc, WR_DATA, r_inc, clr_err,
        output RD_DATA, rd_valid, w_full, r_empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: registered write port, asynchronous read port, no reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, occupancy, flags, sticky errors, read port.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_LEVEL   = AF_LEVEL_DEF,
    parameter int AE_LEVEL   = AE_LEVEL_DEF
) (
    input  logic      CLK,
    input  logic      RST,
    sync_fifo_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  overflow;
    logic                  underflow;

    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign wr_acc = bus.w_inc & ~full;
    assign rd_acc = bus.r_inc & ~empty;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (CLK),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.WR_DATA),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
        end
    end

    // A fresh error outranks clr_err in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.w_inc && full) begin
                overflow <= 1'b1;
            end else if (bus.clr_err) begin
                overflow <= 1'b0;
            end
            if (bus.r_inc && empty) begin
                underflow <= 1'b1;
            end else if (bus.clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    assign bus.count        = count;
    assign bus.w_full       = full;
    assign bus.r_empty      = empty;
    assign bus.almost_full  = (count >= AF_C);
    assign bus.almost_empty = (count <= AE_C);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.RD_DATA  = head;
    assign bus.rd_valid = ~empty;
`else
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= head;
        end
    end

    assign bus.RD_DATA  = rd_data;
    assign bus.rd_valid = rd_valid;
`endif

endmodule
